alu_operand_sequencer: RTL
==========================

# alu_operand_sequencer

Sequential front end for the 8-bit 2:1 operand mux in the ALU datapath. It collects operands over a single 8-bit valid/ready byte stream and holds them stable on the mux inputs together with the select. It captures the mux output into a result register, presents it downstream on a valid/ready handshake, and can optionally chain the previous result in as operand B.

## Interface
- `WIDTH`, default 8: operand and result width; the mux datapath is 8 bits, so only 8 is supported.
- `ACC_EN`, default 1: 1 enables chained mode (`in_chain`); 0 ignores `in_chain`.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: upstream byte valid.
- `in_data` input, WIDTH bits: operand byte.
- `in_sel` input, 1 bit: mux select for this operation; sampled with operand A.
- `in_chain` input, 1 bit: sampled with operand A; 1 means operand B = last result, so no second byte is taken.
- `in_ready` output, 1 bit: block accepts a byte this cycle.
- `mux_sel` output, 1 bit: registered select to the mux.
- `mux_in1` output, WIDTH bits: registered operand A to the mux.
- `mux_in2` output, WIDTH bits: registered operand B to the mux.
- `mux_out` input, WIDTH bits: combinational mux result.
- `res_valid` output, 1 bit: result available.
- `res_data` output, WIDTH bits: registered result.
- `res_ready` input, 1 bit: downstream accepts the result.
- `op_count` output, 8 bits: number of completed (handshaken) results, modulo 256.

## Operation
- The FSM has four states: IDLE, GET_B, DRIVE, HOLD, in a 2-bit encoding.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `opa_q` <= `in_data`, `sel_q` <= `in_sel`, `chain_q` <= `in_chain && ACC_EN`.
  - If the chained bit is set: `opb_q` <= `acc_q` and next state is DRIVE. Otherwise next state is GET_B.
- **GET_B**
  - `in_ready` = 1.
  - On handshake: `opb_q` <= `in_data`, next state DRIVE.
  - With `in_valid` low, the FSM waits indefinitely.
- **DRIVE**
  - `in_ready` = 0.
  - At the end of the cycle: `res_q` <= `mux_out`, `acc_q` <= `mux_out`, next state HOLD.
- **HOLD**
  - `res_valid` = 1 and `in_ready` = 0.
  - On `res_ready`: `op_count` increments (255 wraps to 0) and next state is IDLE.
  - `res_data` stays stable while `res_valid && !res_ready`.
- `mux_sel`, `mux_in1` and `mux_in2` are driven directly from `sel_q`, `opa_q` and `opb_q`. They change only at an operand-capture edge and hold their values through DRIVE and HOLD.
- The block does not interpret the select. The result is whatever the mux produces; the mux convention is sel=0 selects `in1`, sel=1 selects `in2`.
- `acc_q` is 0 after reset. A chained operation before any result therefore uses B = 0x00.
- `in_ready`, `res_valid` and `res_data` are decoded only from state and registers; there is no combinational path from `in_valid` or `res_ready` to any output.
- **Reset (`rst_n` low, any time including mid-operation)**
  - State goes to IDLE immediately.
  - `opa_q`, `opb_q`, `sel_q`, `chain_q`, `res_q`, `acc_q` and `op_count` are cleared to 0.
  - A partially collected operation is discarded and a pending result is dropped.
- **Reset output values:** `in_ready` = 1 (IDLE decode), `res_valid` = 0, `res_data` = 0x00, `mux_sel` = 0, `mux_in1` = 0x00, `mux_in2` = 0x00, `op_count` = 0.

## Timing
- Operand B accepted at edge k: DRIVE occupies cycle k..k+1, the result is captured at edge k+1, and `res_valid` rises after edge k+1. Latency is 2 edges from the B handshake to `res_valid`.
- Chained operation: the A handshake at edge k has the same 2-edge latency to `res_valid`.
- Minimum throughput with `res_ready` held high:
  - 4 cycles per operation in normal mode (IDLE, GET_B, DRIVE, HOLD).
  - 3 cycles per operation in chained mode.
- Path constraint: `mux_out` must settle within one clock period from the mux input registers to `res_q`.
- `in_data` and `in_sel` values present while `in_ready` = 0 are ignored.

## Test plan
- **Normal, sel=0:** reset, then send A=0x3C (`in_sel`=0), B=0xA5, with `res_ready`=1.
  - `mux_in1`=0x3C, `mux_in2`=0xA5, `mux_sel`=0.
  - `res_data`=0x3C with `res_valid` for exactly 1 cycle, 2 edges after the B handshake.
  - `op_count`=1.
- **Normal, sel=1:** same operands with `in_sel`=1.
  - `res_data`=0xA5.
  - Repeat 256 operations and check `op_count` wraps to 0x00.
- **Chained:** after result 0xA5, send A=0x11 with `in_chain`=1 and `in_sel`=1.
  - No GET_B cycle occurs.
  - `mux_in2`=0xA5 and `res_data`=0xA5.
  - With `ACC_EN`=0, the same stimulus waits for a B byte.
- **Backpressure:** hold `res_ready`=0 for 5 cycles in HOLD.
  - `res_valid` stays 1, `res_data` is stable, `in_ready`=0, and bytes offered are not consumed.
  - `res_ready`=1 returns the FSM to IDLE on the next edge.
- **Upstream stall:** drop `in_valid` for 3 cycles in GET_B.
  - The FSM stays in GET_B and `mux_in1` keeps holding the already-captured operand A.
  - The B handshake then proceeds normally.
- **Reset mid-operation:** assert `rst_n` low asynchronously during GET_B, then again during HOLD.
  - Outputs immediately take their reset values: `res_valid`=0, `res_data`=0x00, mux outputs 0x00, `op_count`=0.
  - The first chained operation after reset uses B=0x00.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the 8-bit 2:1 ALU mux: collects A (and B unless chained), drives the mux, registers the result.
// Latency: 2 edges from the B handshake (or the chained A handshake) to res_valid.
// Backpressure: in_ready low from DRIVE until the result handshakes; res_data is held while res_ready is low.
module alu_operand_sequencer #(
  parameter int WIDTH  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_chain,
  output logic             in_ready,
  output logic             mux_sel,
  output logic [WIDTH-1:0] mux_in1,
  output logic [WIDTH-1:0] mux_in2,
  input  logic [WIDTH-1:0] mux_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    DRIVE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, acc_q;
  logic             sel_q;
  logic [7:0]       cnt_q;
  logic             chain_a;
  logic             take_a, take_b, capture, retire;

  assign chain_a = in_chain && ACC_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take_a  = 1'b0;
    take_b  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          take_a  = 1'b1;
          state_d = chain_a ? DRIVE : GET_B;
        end
      end
      GET_B: begin
        if (in_valid) begin
          take_b  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Chained B is the previous result, loaded on the same edge as A so the mux inputs change only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q <= '0;
      opb_q <= '0;
      sel_q <= 1'b0;
      res_q <= '0;
      acc_q <= '0;
      cnt_q <= 8'd0;
    end else begin
      if (take_a) begin
        opa_q <= in_data;
        sel_q <= in_sel;
        if (chain_a) opb_q <= acc_q;
      end
      if (take_b) opb_q <= in_data;
      if (capture) begin
        res_q <= mux_out;
        acc_q <= mux_out;
      end
      if (retire) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == GET_B);
  assign res_valid = (state_q == HOLD);
  assign res_data  = res_q;
  assign mux_sel   = sel_q;
  assign mux_in1   = opa_q;
  assign mux_in2   = opb_q;
  assign op_count  = cnt_q;

endmodule
